sdram_frame_sched: RTL and testbench
====================================

Name: sdram_frame_sched

Overview:
- Sequences and arbitrates SDRAM burst traffic between the camera capture write path and the VGA read path of the cmos_sdram_vga design.
- Takes burst-ready requests from the write-side FIFO (filled by the capture stream) and the read-side FIFO (drained by VGA).
- Issues one burst command at a time to the SDRAM controller.
- Manages ping-pong frame buffering in two SDRAM frame regions.

Parameters:
- ADDR_W, 22, SDRAM word-address width.
- BURST, 256, words per burst; FRAME_WORDS must be an integer multiple of it.
- FRAME_WORDS, 307200, 16-bit words per frame (640x480).
- FRAME_STRIDE, 524288, word offset between frame region 0 and region 1; must be ≥ FRAME_WORDS and a power of two.

Ports:
- clk  in  1  system/SDRAM-side clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_frame_start  in  1  1-cycle pulse: capture frame begins (derived from capture sop, already in clk domain).
- rd_frame_start  in  1  1-cycle pulse: VGA frame begins (vsync-derived, clk domain).
- wr_req  in  1  write FIFO holds ≥ BURST words.
- rd_req  in  1  read FIFO has room for ≥ BURST words.
- cmd_ready  in  1  SDRAM controller accepts a command this cycle.
- burst_done  in  1  1-cycle pulse: the accepted burst has fully completed.
- cmd_valid  out  1  command offer.
- cmd_wr  out  1  1 = write burst, 0 = read burst.
- cmd_addr  out  ADDR_W  burst start word address.
- wr_bank  out  1  frame region currently written.
- rd_bank  out  1  frame region currently read.
- rd_frame_valid  out  1  at least one complete frame has been written.
- wr_active  out  1  write frame in progress.
- rd_active  out  1  read frame in progress.

Behaviour:
- Reset values: cmd_valid 0, cmd_wr 0, cmd_addr 0, wr_bank 0, rd_bank 1, rd_frame_valid 0, wr_active 0, rd_active 0. Internal state: done_bank 1, wr_off 0, rd_off 0, last_grant = read, both start-pending flags 0, FSM in IDLE.
- Reset mid-burst: all state returns to reset values immediately. A burst_done arriving afterwards is ignored because the FSM is in IDLE.
- Frame-start pulses set pending flags. A flag is consumed only in IDLE, before arbitration, so a pulse during a burst takes effect after that burst ends. A repeat pulse while the flag is already pending is absorbed.
- Consuming a write start sets wr_off to 0 and wr_active to 1. If wr_active was already 1, this is a resync: the partial frame is abandoned and wr_bank is unchanged.
- Consuming a read start sets rd_bank to done_bank, rd_off to 0 and rd_active to 1.
- Write eligibility: wr_req & wr_active. Read eligibility: rd_req & rd_active.
- FSM states:
  - IDLE: consume pending starts, then arbitrate. If only one side is eligible, grant it. If both are eligible, grant the side opposite last_grant (round-robin). On grant, go to CMD with cmd_valid=1, cmd_wr set and cmd_addr = bank*FRAME_STRIDE + off, all registered. The command appears the cycle after the grant decision.
  - CMD: hold cmd_valid, cmd_wr and cmd_addr stable until the cycle cmd_ready=1. In that cycle, clear cmd_valid on the next edge, update last_grant and go to WAIT.
  - WAIT: on burst_done, add BURST to the granted side's offset and go to IDLE. burst_done in IDLE or CMD is ignored.
- Write frame completion: when the updated wr_off equals FRAME_WORDS, set done_bank ← wr_bank, wr_bank ← ~wr_bank, wr_off ← 0, wr_active ← 0 and rd_frame_valid ← 1 (sticky until reset).
- Read frame completion: when the updated rd_off equals FRAME_WORDS, set rd_off ← 0 and rd_active ← 0. Reads stop until the next rd_frame_start.
- A read start with rd_frame_valid=0 still runs: it reads region 1 with undefined content. rd_frame_valid lets downstream blank the display.
- Tearing policy: the writer may enter the region being read. No frame dropping; the scheme accepts this with two regions.
- Offsets are ADDR_W-bit and never exceed FRAME_WORDS. Address = {bank, off} because FRAME_STRIDE is a power of two.
- One outstanding command maximum; no back-to-back issue without passing through IDLE (minimum 1 IDLE cycle).

Test Plan (FRAME_WORDS=16, BURST=4, FRAME_STRIDE=32, cmd_ready tied 1, burst_done 3 cycles after accept):
- Pulse wr_frame_start, hold wr_req=1 → four write commands at addr 0,4,8,12. After the 4th burst_done: wr_bank=1, wr_active=0, rd_frame_valid=1, done_bank=0.
- After the above, pulse rd_frame_start with rd_req=1 → rd_bank=0; reads at 0,4,8,12, then rd_active=0 and no further reads.
- Both wr and rd active with wr_req=rd_req=1 → grants alternate W,R,W,R. The first grant is write (last_grant reset = read). Write addrs 32,36,… and read addrs 0,4,….
- cmd_ready held 0 for 5 cycles in CMD → cmd_valid, cmd_wr and cmd_addr stable all 5 cycles; the accept on cycle 6 produces exactly one command.
- wr_frame_start pulsed during WAIT at wr_off=8 → after burst_done the offset is updated, then IDLE resets wr_off to 0. The next write addr is bank*32+0 and wr_bank is unchanged.
- Assert rst during WAIT → all outputs at reset values next cycle. A late burst_done produces no offset change, and no command is issued until a new frame start.

Source files
------------

// File: rtl/sdram_frame_sched_if.sv
// Command/status bundle between the frame scheduler and its surroundings
// (FIFO level flags, frame-start pulses, SDRAM controller command port).
interface sdram_frame_sched_if #(
  parameter int ADDR_W = 22
);
  logic              wr_frame_start;
  logic              rd_frame_start;
  logic              wr_req;
  logic              rd_req;
  logic              cmd_ready;
  logic              burst_done;
  logic              cmd_valid;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic              wr_bank;
  logic              rd_bank;
  logic              rd_frame_valid;
  logic              wr_active;
  logic              rd_active;

  modport master (
    input  wr_frame_start, rd_frame_start, wr_req, rd_req, cmd_ready, burst_done,
    output cmd_valid, cmd_wr, cmd_addr, wr_bank, rd_bank, rd_frame_valid,
           wr_active, rd_active
  );

  modport slave (
    output wr_frame_start, rd_frame_start, wr_req, rd_req, cmd_ready, burst_done,
    input  cmd_valid, cmd_wr, cmd_addr, wr_bank, rd_bank, rd_frame_valid,
           wr_active, rd_active
  );
endinterface

// File: rtl/sdram_frame_sched.sv
// Arbitrates camera-write and VGA-read SDRAM bursts, one command outstanding,
// with ping-pong frame regions addressed as {bank, offset}.
module sdram_frame_sched #(
  parameter int ADDR_W       = 22,
  parameter int BURST        = 256,
  parameter int FRAME_WORDS  = 307200,
  parameter int FRAME_STRIDE = 524288
) (
  input  logic                clk,
  input  logic                rst,
  sdram_frame_sched_if.master bus
);

  localparam int                BANK_SH = $clog2(FRAME_STRIDE);
  localparam logic [ADDR_W-1:0] BURST_W = ADDR_W'(BURST);
  localparam logic [ADDR_W-1:0] FRAME_W = ADDR_W'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;

  state_t            state, state_n;
  logic              cmd_valid, cmd_valid_n;
  logic              cmd_wr, cmd_wr_n;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_n;
  logic              wr_bank, wr_bank_n;
  logic              rd_bank, rd_bank_n;
  logic              done_bank, done_bank_n;
  logic [ADDR_W-1:0] wr_off, wr_off_n;
  logic [ADDR_W-1:0] rd_off, rd_off_n;
  logic              wr_active, wr_active_n;
  logic              rd_active, rd_active_n;
  logic              rd_frame_valid, rd_frame_valid_n;
  logic              last_wr, last_wr_n;
  logic              wr_pend, wr_pend_n;
  logic              rd_pend, rd_pend_n;
  logic              wr_elig, rd_elig, pick_wr;
  logic [ADDR_W-1:0] wr_upd, rd_upd;

  function automatic logic [ADDR_W-1:0] frame_addr(input logic bank,
                                                   input logic [ADDR_W-1:0] off);
    return ({{(ADDR_W-1){1'b0}}, bank} << BANK_SH) | off;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cmd_valid      <= 1'b0;
      cmd_wr         <= 1'b0;
      cmd_addr       <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b1;
      done_bank      <= 1'b1;
      wr_off         <= '0;
      rd_off         <= '0;
      wr_active      <= 1'b0;
      rd_active      <= 1'b0;
      rd_frame_valid <= 1'b0;
      last_wr        <= 1'b0;
      wr_pend        <= 1'b0;
      rd_pend        <= 1'b0;
    end else begin
      state          <= state_n;
      cmd_valid      <= cmd_valid_n;
      cmd_wr         <= cmd_wr_n;
      cmd_addr       <= cmd_addr_n;
      wr_bank        <= wr_bank_n;
      rd_bank        <= rd_bank_n;
      done_bank      <= done_bank_n;
      wr_off         <= wr_off_n;
      rd_off         <= rd_off_n;
      wr_active      <= wr_active_n;
      rd_active      <= rd_active_n;
      rd_frame_valid <= rd_frame_valid_n;
      last_wr        <= last_wr_n;
      wr_pend        <= wr_pend_n;
      rd_pend        <= rd_pend_n;
    end
  end

  always_comb begin
    state_n          = state;
    cmd_valid_n      = cmd_valid;
    cmd_wr_n         = cmd_wr;
    cmd_addr_n       = cmd_addr;
    wr_bank_n        = wr_bank;
    rd_bank_n        = rd_bank;
    done_bank_n      = done_bank;
    wr_off_n         = wr_off;
    rd_off_n         = rd_off;
    wr_active_n      = wr_active;
    rd_active_n      = rd_active;
    rd_frame_valid_n = rd_frame_valid;
    last_wr_n        = last_wr;
    wr_pend_n        = wr_pend | bus.wr_frame_start;
    rd_pend_n        = rd_pend | bus.rd_frame_start;
    wr_elig          = 1'b0;
    rd_elig          = 1'b0;
    pick_wr          = 1'b0;
    wr_upd           = wr_off + BURST_W;
    rd_upd           = rd_off + BURST_W;

    case (state)
      S_IDLE: begin
        // Starts are applied first so arbitration sees the fresh frame state.
        if (wr_pend) begin
          wr_off_n    = '0;
          wr_active_n = 1'b1;
          wr_pend_n   = bus.wr_frame_start;
        end
        if (rd_pend) begin
          rd_bank_n   = done_bank;
          rd_off_n    = '0;
          rd_active_n = 1'b1;
          rd_pend_n   = bus.rd_frame_start;
        end
        wr_elig = bus.wr_req & wr_active_n;
        rd_elig = bus.rd_req & rd_active_n;
        pick_wr = (wr_elig & rd_elig) ? ~last_wr : wr_elig;
        if (wr_elig | rd_elig) begin
          state_n     = S_CMD;
          cmd_valid_n = 1'b1;
          cmd_wr_n    = pick_wr;
          cmd_addr_n  = pick_wr ? frame_addr(wr_bank_n, wr_off_n)
                                : frame_addr(rd_bank_n, rd_off_n);
        end
      end
      S_CMD: begin
        if (bus.cmd_ready) begin
          cmd_valid_n = 1'b0;
          last_wr_n   = cmd_wr;
          state_n     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.burst_done) begin
          state_n = S_IDLE;
          if (last_wr) begin
            if (wr_upd == FRAME_W) begin
              done_bank_n      = wr_bank;
              wr_bank_n        = ~wr_bank;
              wr_off_n         = '0;
              wr_active_n      = 1'b0;
              rd_frame_valid_n = 1'b1;
            end else begin
              wr_off_n = wr_upd;
            end
          end else begin
            if (rd_upd == FRAME_W) begin
              rd_off_n    = '0;
              rd_active_n = 1'b0;
            end else begin
              rd_off_n = rd_upd;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.cmd_valid      = cmd_valid;
  assign bus.cmd_wr         = cmd_wr;
  assign bus.cmd_addr       = cmd_addr;
  assign bus.wr_bank        = wr_bank;
  assign bus.rd_bank        = rd_bank;
  assign bus.rd_frame_valid = rd_frame_valid;
  assign bus.wr_active      = wr_active;
  assign bus.rd_active      = rd_active;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Directed bench for sdram_frame_sched: small frames, controller model that
// completes each accepted burst three cycles later.
module tb_sdram_frame_sched;

  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sdram_frame_sched_if #(.ADDR_W(AW)) bus ();

  sdram_frame_sched #(
    .ADDR_W(AW), .BURST(4), .FRAME_WORDS(16), .FRAME_STRIDE(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
  } cmd_t;

  typedef struct {
    logic          wr_req;
    logic          rd_req;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  cmd_t acc_q[$];
  vec_t vecs[16];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  // Controller model: records accepted commands, returns burst_done 3 cycles later.
  initial begin
    bus.burst_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.burst_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) bus.burst_done = 1'b1;
      end
      if (bus.cmd_valid && bus.cmd_ready && !rst) begin
        acc_q.push_back('{wr: bus.cmd_wr, addr: bus.cmd_addr});
        done_cnt = 3;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_cmd(input string nm, input logic ew, input logic [AW-1:0] ea);
    cmd_t c;
    bit   got = 0;
    for (int k = 0; k < 60; k++) begin
      if (acc_q.size() > 0) begin
        got = 1;
        break;
      end
      tick();
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s: no command within 60 cycles, expected wr=%0d addr=%0h", nm, ew, ea);
    end else begin
      c = acc_q.pop_front();
      check({nm, " wr"}, 32'(c.wr), 32'(ew));
      check({nm, " addr"}, 32'(c.addr), 32'(ea));
    end
  endtask

  task automatic pulse(input logic w, input logic r);
    bus.wr_frame_start = w;
    bus.rd_frame_start = r;
    tick();
    bus.wr_frame_start = 1'b0;
    bus.rd_frame_start = 1'b0;
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.wr_req = vecs[i].wr_req;
      bus.rd_req = vecs[i].rd_req;
      expect_cmd($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_addr);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
    check({tag, " cmd_wr"}, 32'(bus.cmd_wr), 32'd0);
    check({tag, " cmd_addr"}, 32'(bus.cmd_addr), 32'd0);
    check({tag, " wr_bank"}, 32'(bus.wr_bank), 32'd0);
    check({tag, " rd_bank"}, 32'(bus.rd_bank), 32'd1);
    check({tag, " rd_frame_valid"}, 32'(bus.rd_frame_valid), 32'd0);
    check({tag, " wr_active"}, 32'(bus.wr_active), 32'd0);
    check({tag, " rd_active"}, 32'(bus.rd_active), 32'd0);
  endtask

  initial begin
    bit seen;

    // first write frame into region 0
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 22'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 22'd4};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 22'd8};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 22'd12};
    // read back region 0
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 22'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 22'd4};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 22'd8};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 22'd12};
    // concurrent write to region 1 and read of region 0, round-robin
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 22'd32};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 22'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 22'd36};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 22'd4};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 22'd40};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 22'd8};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 22'd44};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 22'd12};

    bus.wr_frame_start = 1'b0;
    bus.rd_frame_start = 1'b0;
    bus.wr_req         = 1'b0;
    bus.rd_req         = 1'b0;
    bus.cmd_ready      = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("reset");

    // write frame
    pulse(1'b1, 1'b0);
    run_vecs(0, 3);
    repeat (4) tick();
    check("wframe wr_bank", 32'(bus.wr_bank), 32'd1);
    check("wframe wr_active", 32'(bus.wr_active), 32'd0);
    check("wframe rd_frame_valid", 32'(bus.rd_frame_valid), 32'd1);
    repeat (10) tick();
    check("wframe no extra cmd", 32'(acc_q.size()), 32'd0);

    // read frame from the completed region
    pulse(1'b0, 1'b1);
    run_vecs(4, 7);
    check("rframe rd_bank", 32'(bus.rd_bank), 32'd0);
    repeat (4) tick();
    check("rframe rd_active", 32'(bus.rd_active), 32'd0);
    repeat (10) tick();
    check("rframe no extra cmd", 32'(acc_q.size()), 32'd0);

    // both sides running: W,R,W,R...
    pulse(1'b1, 1'b1);
    run_vecs(8, 15);
    repeat (4) tick();
    check("alt wr_bank", 32'(bus.wr_bank), 32'd0);
    check("alt wr_active", 32'(bus.wr_active), 32'd0);
    check("alt rd_active", 32'(bus.rd_active), 32'd0);
    repeat (10) tick();
    check("alt no extra cmd", 32'(acc_q.size()), 32'd0);

    // stall in CMD; a new read start now picks region 1
    bus.wr_req    = 1'b1;
    bus.rd_req    = 1'b0;
    bus.cmd_ready = 1'b0;
    pulse(1'b1, 1'b1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cmd_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("stall cmd_valid seen", 32'(seen), 32'd1);
    check("stall rd_bank", 32'(bus.rd_bank), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d cmd_valid", k), 32'(bus.cmd_valid), 32'd1);
      check($sformatf("stall%0d cmd_wr", k), 32'(bus.cmd_wr), 32'd1);
      check($sformatf("stall%0d cmd_addr", k), 32'(bus.cmd_addr), 32'd0);
      if (k < 4) tick();
    end
    bus.cmd_ready = 1'b1;
    bus.wr_req    = 1'b0;
    expect_cmd("stall accept", 1'b1, 22'd0);
    repeat (10) tick();
    check("stall single cmd", 32'(acc_q.size()), 32'd0);
    check("stall cmd_valid low", 32'(bus.cmd_valid), 32'd0);

    // write resync during WAIT at offset 8
    bus.wr_req = 1'b1;
    expect_cmd("resync w4", 1'b1, 22'd4);
    expect_cmd("resync w8", 1'b1, 22'd8);
    pulse(1'b1, 1'b0);
    expect_cmd("resync restart", 1'b1, 22'd0);
    check("resync wr_bank", 32'(bus.wr_bank), 32'd0);
    check("resync wr_active", 32'(bus.wr_active), 32'd1);

    // reset while the restart burst is in WAIT
    bus.rd_req = 1'b1;
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (15) tick();
    check("midrst no cmd", 32'(acc_q.size()), 32'd0);
    check("midrst cmd_valid", 32'(bus.cmd_valid), 32'd0);
    bus.rd_req = 1'b0;
    pulse(1'b1, 1'b0);
    expect_cmd("midrst restart", 1'b1, 22'd0);

    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
